seven_seg_scan_driver: RTL and testbench

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display. It takes the 32-bit word chosen by the display-select wrapper, latches it once per scan frame so digits never tear mid-frame, and hex-decodes one 16-bit half. It scans the four digits, generating per-digit blink and decimal-point control. Its own prescalers replace the wrapper's free-running counter taps; registered SEGMENT/AN go straight to the pins.

---
 rtl/seven_seg_scan_driver.sv | 127 ++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Latches the display word once per scan frame and scans digits with blink/DP control.
module seven_seg_scan_driver #(
  parameter int SCAN_DIV     = 65536,
  parameter int BLINK_FRAMES = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] disp_num,
  input  logic        high_degree,
  input  logic [3:0]  point_mask,
  input  logic [3:0]  blink_mask,
  output logic [7:0]  SEGMENT,
  output logic [3:0]  AN,
  output logic        frame_start
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_TC = FW'(BLINK_FRAMES - 1);

  // Active-low hex glyphs, bit order g,f,e,d,c,b,a.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  logic [PW-1:0] r_presc;
  logic [1:0]    r_digit;
  logic [FW-1:0] r_frame;
  logic          r_blink;
  logic [31:0]   r_latch;
  logic          r_hd;
  logic          r_load_pending;
  logic [7:0]    r_seg;
  logic [3:0]    r_an;

  logic          w_tc;
  logic          w_wrap;
  logic          w_load;
  logic [31:0]   w_word;
  logic          w_hd;
  logic [15:0]   w_half;
  logic [3:0]    w_nib;
  logic [3:0]    w_an_next;
  logic [7:0]    w_seg_next;

  // Scan decode; the first frame after reset reads the inputs directly so
  // digit 0 already shows the word being latched on that same edge.
  always_comb begin
    w_tc       = (r_presc == PRESC_TC);
    w_wrap     = w_tc && (r_digit == 2'd3);
    w_load     = r_load_pending || w_wrap;
    w_word     = r_load_pending ? disp_num : r_latch;
    w_hd       = r_load_pending ? high_degree : r_hd;
    w_half     = w_hd ? w_word[31:16] : w_word[15:0];
    case (r_digit)
      2'd0:    w_nib = w_half[3:0];
      2'd1:    w_nib = w_half[7:4];
      2'd2:    w_nib = w_half[11:8];
      2'd3:    w_nib = w_half[15:12];
      default: w_nib = w_half[3:0];
    endcase
    w_an_next  = (r_blink && blink_mask[r_digit]) ? 4'hF : ~(4'b0001 << r_digit);
    w_seg_next = {~point_mask[r_digit], hex7(w_nib)};
  end

  // Prescaler, digit/frame counters, frame latch and pin registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc        <= '0;
      r_digit        <= 2'd0;
      r_frame        <= '0;
      r_blink        <= 1'b0;
      r_latch        <= 32'h0000_0000;
      r_hd           <= 1'b0;
      r_load_pending <= 1'b1;
      r_seg          <= 8'hFF;
      r_an           <= 4'hF;
    end else begin
      r_presc        <= w_tc ? '0 : r_presc + PW'(1);
      r_load_pending <= 1'b0;
      if (w_tc) begin
        r_digit <= r_digit + 2'd1;
      end
      if (w_load) begin
        r_latch <= disp_num;
        r_hd    <= high_degree;
      end
      if (w_wrap) begin
        if (r_frame == FRAME_TC) begin
          r_frame <= '0;
          r_blink <= ~r_blink;
        end else begin
          r_frame <= r_frame + FW'(1);
        end
      end
      r_seg <= w_seg_next;
      r_an  <= w_an_next;
    end
  end

  assign SEGMENT     = r_seg;
  assign AN          = r_an;
  assign frame_start = w_load & ~rst;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: cycle-count model of the scan plus directed literal checks.
module tb_seven_seg_scan_driver;

  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FRAME_LEN = 4 * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] disp_num;
  logic        high_degree;
  logic [3:0]  point_mask;
  logic [3:0]  blink_mask;
  logic [7:0]  SEGMENT;
  logic [3:0]  AN;
  logic        frame_start;

  int checks   = 0;
  int failures = 0;

  logic [6:0]  hex_tab [16];
  int          n;
  logic [31:0] m_word;
  logic        m_hd;
  logic [3:0]  exp_an;
  logic [7:0]  exp_seg;
  logic        primed = 1'b0;

  seven_seg_scan_driver #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk         (clk),
    .rst         (rst),
    .disp_num    (disp_num),
    .high_degree (high_degree),
    .point_mask  (point_mask),
    .blink_mask  (blink_mask),
    .SEGMENT     (SEGMENT),
    .AN          (AN),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, want, $time);
    end
  endtask

  // One clock cycle: model the cycle being entered, then compare the outputs it produces.
  task automatic step();
    int          digit;
    int          frame;
    int          nib;
    logic        blink;
    logic        was_rst;
    logic        is_load;
    logic [15:0] half;
    #1;
    was_rst = rst;
    is_load = !rst && (n == 0 || (n % FRAME_LEN) == FRAME_LEN - 1);
    if (primed) chk("frame_start", {7'd0, frame_start}, {7'd0, is_load});
    if (was_rst) begin
      exp_an  = 4'hF;
      exp_seg = 8'hFF;
      n       = 0;
    end else begin
      if (n == 0) begin
        m_word = disp_num;
        m_hd   = high_degree;
      end
      digit   = (n / SD) % 4;
      frame   = n / FRAME_LEN;
      blink   = ((frame / BF) % 2) == 1;
      half    = m_hd ? m_word[31:16] : m_word[15:0];
      nib     = int'((half >> (4 * digit)) & 16'h000F);
      exp_an  = (blink && blink_mask[digit]) ? 4'hF : ~(4'b0001 << digit);
      exp_seg = {~point_mask[digit], hex_tab[nib]};
      if (n != 0 && is_load) begin
        m_word = disp_num;
        m_hd   = high_degree;
      end
      n++;
    end
    @(negedge clk);
    if (was_rst) primed = 1'b1;
    if (primed) begin
      chk("model_AN", {4'd0, AN}, {4'd0, exp_an});
      chk("model_SEGMENT", SEGMENT, exp_seg);
    end
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic lit(input string name, input logic [3:0] an_w, input logic [7:0] seg_w);
    chk({name, "_AN"}, {4'd0, AN}, {4'd0, an_w});
    chk({name, "_SEG"}, SEGMENT, seg_w);
  endtask

  initial begin
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    n = 0;
    m_word = 32'h0;
    m_hd = 1'b0;
    exp_an = 4'hF;
    exp_seg = 8'hFF;
    rst = 1'b1;
    disp_num = 32'h0000_1234;
    high_degree = 1'b0;
    point_mask = 4'b0000;
    blink_mask = 4'b0000;
    @(negedge clk);

    run(2);
    lit("reset", 4'hF, 8'hFF);
    chk("reset_frame_start", {7'd0, frame_start}, 8'd0);

    rst = 1'b0;
    run(1);  lit("f0_d0", 4'hE, 8'h99);
    run(4);  lit("f0_d1", 4'hD, 8'hB0);
    run(4);  lit("f0_d2", 4'hB, 8'hA4);
    run(4);  lit("f0_d3", 4'h7, 8'hF9);
    run(4);  lit("f1_d0", 4'hE, 8'h99);

    disp_num = 32'hFFFF_8888;
    run(4);  lit("midframe_hold", 4'hD, 8'hB0);
    run(12); lit("new_frame_8", 4'hE, 8'h80);

    disp_num = 32'hABCD_0000;
    high_degree = 1'b1;
    run(16); lit("hi_d0", 4'hE, 8'hA1);
    run(4);  lit("hi_d1", 4'hD, 8'hC6);
    run(4);  lit("hi_d2", 4'hB, 8'h83);
    run(4);  lit("hi_d3", 4'h7, 8'h88);

    blink_mask = 4'b0001;
    point_mask = 4'b0100;
    run(4);  lit("blink_vis", 4'hE, 8'hA1);
    run(32); lit("blink_blank", 4'hF, 8'hA1);
    run(4);  lit("blink_other", 4'hD, 8'hC6);
    run(4);  lit("dp_digit2", 4'hB, 8'h03);

    rst = 1'b1;
    disp_num = 32'h0000_5678;
    high_degree = 1'b0;
    run(1);  lit("midreset", 4'hF, 8'hFF);
    run(1);  lit("reset_hold", 4'hF, 8'hFF);
    rst = 1'b0;
    run(1);  lit("restart_d0", 4'hE, 8'h80);
    run(4);  lit("restart_d1", 4'hD, 8'hF8);
    run(4);  lit("restart_d2", 4'hB, 8'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
